// File: rtl/dmem_sram_bridge_pkg.sv
// Shared state encodings, size codes and the alignment rule for the memory-stage SRAM bridge.
package dmem_sram_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   // Halfwords need an even address, words a 4-byte aligned one.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      return ((size == SZ_H) && addr_lo[0]) || ((size == SZ_W) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/dmem_sram_bridge_align.sv
// addr_align_chk: combinational misalignment detector, used only when DMEM_ALIGN_CHECK_EN is defined.
module addr_align_chk
   import dmem_sram_bridge_pkg::*;
(
   input  logic [1:0] i_size,
   input  logic [1:0] i_addr_lo,
   output logic       o_misal
);

   assign o_misal = misaligned(i_size, i_addr_lo);

endmodule

// File: rtl/dmem_sram_bridge.sv
// Memory-stage to SRAM-like bus bridge: one registered bus transaction per access, read data held across stalls.
// Optional alignment trapping is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_sram_bridge
   import dmem_sram_bridge_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mem_en,
   input  logic [DW/8-1:0] mem_wen,
   input  logic [1:0]      mem_size,
   input  logic [AW-1:0]   mem_addr,
   input  logic [DW-1:0]   mem_wdata,
   input  logic            ext_stall,
   input  logic            flush,
   output logic [DW-1:0]   mem_rdata,
   output logic            stall_o,
   output logic            adel_o,
   output logic            ades_o,
   output logic            data_req,
   output logic            data_wr,
   output logic [1:0]      data_size,
   output logic [DW/8-1:0] data_wstrb,
   output logic [AW-1:0]   data_addr,
   output logic [DW-1:0]   data_wdata,
   input  logic            data_addr_ok,
   input  logic            data_data_ok,
   input  logic [DW-1:0]   data_rdata
);

   state_t            r_state;
   logic              r_req;
   logic              r_wr;
   logic [1:0]        r_size;
   logic [DW/8-1:0]   r_wstrb;
   logic [AW-1:0]     r_addr;
   logic [DW-1:0]     r_wdata;
   logic [DW-1:0]     r_rbuf;
   logic              r_discard;

   logic w_store;
   logic w_misal;
   logic w_accept;
   logic w_kill;
   logic w_done_now;

   assign w_store = |mem_wen;

`ifdef DMEM_ALIGN_CHECK_EN
   addr_align_chk u_align (
      .i_size    (mem_size),
      .i_addr_lo (mem_addr[1:0]),
      .o_misal   (w_misal)
   );
   assign adel_o = (r_state == ST_IDLE) && mem_en && !flush && w_misal && !w_store;
   assign ades_o = (r_state == ST_IDLE) && mem_en && !flush && w_misal &&  w_store;
`else
   assign w_misal = 1'b0;
   assign adel_o  = 1'b0;
   assign ades_o  = 1'b0;
`endif

   assign w_accept   = (r_state == ST_IDLE) && mem_en && !flush && !w_misal;
   // A flush anywhere in the transaction, including the completing cycle, kills the result.
   assign w_kill     = r_discard || flush;
   assign w_done_now = (r_state == ST_DATA) && data_data_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_req     <= 1'b0;
         r_wr      <= 1'b0;
         r_size    <= '0;
         r_wstrb   <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rbuf    <= '0;
         r_discard <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_addr  <= mem_addr;
                  r_wstrb <= mem_wen;
                  r_size  <= mem_size;
                  r_wdata <= mem_wdata;
                  r_wr    <= w_store;
                  r_req   <= 1'b1;
                  r_state <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (flush) r_discard <= 1'b1;
               if (data_addr_ok) begin
                  r_req   <= 1'b0;
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (data_data_ok) begin
                  if (!w_kill) r_rbuf <= data_rdata;
                  r_discard <= 1'b0;
                  r_state   <= (!w_kill && ext_stall) ? ST_DONE : ST_IDLE;
               end else if (flush) begin
                  r_discard <= 1'b1;
               end
            end
            ST_DONE: begin
               if (!ext_stall || flush) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign mem_rdata  = w_done_now ? data_rdata : r_rbuf;
   assign stall_o    = w_accept || (r_state == ST_ADDR) || ((r_state == ST_DATA) && !data_data_ok);

   assign data_req   = r_req;
   assign data_wr    = r_wr;
   assign data_size  = r_size;
   assign data_wstrb = r_wstrb;
   assign data_addr  = r_addr;
   assign data_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Scoreboard bench for dmem_sram_bridge: driver queues expected bus requests, a bus-side monitor checks them.
module tb_dmem_sram_bridge;

   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            mem_en;
   logic [3:0]      mem_wen;
   logic [1:0]      mem_size;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic            ext_stall;
   logic            flush;
   logic [DW-1:0]   mem_rdata;
   logic            stall_o;
   logic            adel_o;
   logic            ades_o;
   logic            data_req;
   logic            data_wr;
   logic [1:0]      data_size;
   logic [3:0]      data_wstrb;
   logic [AW-1:0]   data_addr;
   logic [DW-1:0]   data_wdata;
   logic            data_addr_ok;
   logic            data_data_ok;
   logic [DW-1:0]   data_rdata;

   dmem_sram_bridge #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .ext_stall(ext_stall), .flush(flush),
      .mem_rdata(mem_rdata), .stall_o(stall_o), .adel_o(adel_o), .ades_o(ades_o),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  wen;
      logic [1:0]  size;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      int          ad;
      int          dd;
      logic [31:0] rdata;
   } bus_t;

   req_t        q_req[$];
   bus_t        q_bus[$];
   logic [31:0] m_buf;
   int          n_pass = 0;
   int          n_tot  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic summary_and_finish();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   endtask

   // Every cycle a request is visible it must match the oldest outstanding access.
   req_t e;
   always @(negedge clk) begin
      if (!rst && data_req) begin
         if (q_req.size() == 0) chk("spurious_req", 32'd1, 32'd0);
         else begin
            e = q_req[0];
            chk("req_addr",  data_addr,  e.addr);
            chk("req_wr",    {31'd0, data_wr}, {31'd0, |e.wen});
            chk("req_wstrb", {28'd0, data_wstrb}, {28'd0, e.wen});
            chk("req_wdata", data_wdata, e.wdata);
            chk("req_size",  {30'd0, data_size}, {30'd0, e.size});
            if (data_addr_ok) void'(q_req.pop_front());
         end
      end
   end

   // Bus slave: per request, wait ad cycles before addr_ok, then dd cycles before data_ok.
   bus_t b;
   initial begin
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = $urandom;
      forever begin
         @(posedge clk); #1;
         if (data_req && !rst) begin
            if (q_bus.size() == 0) begin
               chk("bus_entry", 32'd0, 32'd1);
               b.ad = 0; b.dd = 0; b.rdata = 32'd0;
            end else b = q_bus.pop_front();
            repeat (b.ad) begin @(posedge clk); #1; end
            data_addr_ok = 1'b1;
            @(posedge clk); #1;
            data_addr_ok = 1'b0;
            repeat (b.dd) begin @(posedge clk); #1; end
            data_data_ok = 1'b1;
            data_rdata   = b.rdata;
            @(posedge clk); #1;
            data_data_ok = 1'b0;
            data_rdata   = $urandom;
         end
      end
   end

   // One access: a finished transaction takes 2 stalled cycles plus every bus wait cycle.
   task automatic access(input logic [31:0] a, input logic [3:0] wen, input logic [1:0] sz,
                         input logic [31:0] wd, input int ad, input int dd, input logic [31:0] rd,
                         input int flush_at, input int post);
      int   cyc;
      int   stalled;
      bit   flushed;
      req_t r;
      bus_t bb;
      @(posedge clk); #1;
      r.addr = a; r.wen = wen; r.size = sz; r.wdata = wd;
      q_req.push_back(r);
      bb.ad = ad; bb.dd = dd; bb.rdata = rd;
      q_bus.push_back(bb);
      mem_en = 1'b1; mem_wen = wen; mem_size = sz; mem_addr = a; mem_wdata = wd;
      flush = 1'b0; ext_stall = (post > 0);
      cyc = 0; stalled = 0; flushed = 0;
      forever begin
         @(negedge clk);
         if (stalled == 0) begin
            chk("adel_aligned", {31'd0, adel_o}, 32'd0);
            chk("ades_aligned", {31'd0, ades_o}, 32'd0);
         end
         if (!stall_o) break;
         stalled++;
         if (stalled > 40) begin
            chk("access_timeout", 32'd0, 32'd1);
            summary_and_finish();
         end
         @(posedge clk); #1;
         cyc++;
         if (flush_at != 0 && cyc == flush_at) begin
            flush = 1'b1;
            flushed = 1;
         end
      end
      chk("stall_cycles", stalled, 2 + ad + dd);
      if (!flushed) begin
         chk("rdata_passthru", mem_rdata, rd);
         m_buf = rd;
      end
      @(posedge clk); #1;
      if (!flushed) begin
         for (int k = 0; k < post; k++) begin
            if (k == post - 1) ext_stall = 1'b0;
            @(negedge clk);
            chk("done_stall", {31'd0, stall_o}, 32'd0);
            chk("done_hold", mem_rdata, m_buf);
            @(posedge clk); #1;
         end
      end
      mem_en = 1'b0; flush = 1'b0; ext_stall = 1'b0; mem_wen = 4'd0;
      @(negedge clk);
      chk("buf_idle", mem_rdata, m_buf);
      chk("idle_stall", {31'd0, stall_o}, 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      logic [3:0]  wen;
      int          ad, dd, fl, post;

      rst = 1'b1; mem_en = 1'b0; mem_wen = 4'd0; mem_size = 2'd0; mem_addr = '0;
      mem_wdata = '0; ext_stall = 1'b0; flush = 1'b0; m_buf = 32'd0;
      repeat (2) begin @(posedge clk); #1; end
      chk("rst_req",   {31'd0, data_req}, 32'd0);
      chk("rst_stall", {31'd0, stall_o}, 32'd0);
      chk("rst_rdata", mem_rdata, 32'd0);
      chk("rst_addr",  data_addr, 32'd0);
      chk("rst_wstrb", {28'd0, data_wstrb}, 32'd0);
      rst = 1'b0;

      access(32'h100, 4'b0000, 2'd2, 32'h0BAD_F00D, 0, 0, 32'hDEADBEEF, 0, 0);
      access(32'h103, 4'b1000, 2'd0, 32'h5A5A5A5A, 3, 0, 32'h1111_2222, 0, 0);
      access(32'h200, 4'b0000, 2'd2, 32'h0, 0, 0, 32'h12345678, 0, 3);
      access(32'h204, 4'b0000, 2'd2, 32'h0, 0, 2, 32'hFFFFFFFF, 2, 0);

      // Killed in IDLE: nothing may be requested.
      @(posedge clk); #1;
      mem_en = 1'b1; flush = 1'b1; mem_wen = 4'hF; mem_size = 2'd2; mem_addr = 32'h40;
      repeat (2) begin
         @(negedge clk);
         chk("idle_flush_stall", {31'd0, stall_o}, 32'd0);
         @(posedge clk); #1;
      end
      mem_en = 1'b0; flush = 1'b0; mem_wen = 4'd0;

      // Asynchronous reset in the middle of the address phase.
      @(posedge clk); #1;
      begin
         req_t rr;
         bus_t bq;
         rr.addr = 32'h300; rr.wen = 4'd0; rr.size = 2'd2; rr.wdata = 32'h0;
         q_req.push_back(rr);
         bq.ad = 4; bq.dd = 0; bq.rdata = 32'hCAFE0000;
         q_bus.push_back(bq);
      end
      mem_en = 1'b1; mem_wen = 4'd0; mem_size = 2'd2; mem_addr = 32'h300; mem_wdata = 32'h0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst = 1'b1; mem_en = 1'b0;
      #1;
      chk("arst_req",   {31'd0, data_req}, 32'd0);
      chk("arst_stall", {31'd0, stall_o}, 32'd0);
      chk("arst_addr",  data_addr, 32'd0);
      chk("arst_rdata", mem_rdata, 32'd0);
      chk("arst_wr",    {31'd0, data_wr}, 32'd0);
      chk("arst_size",  {30'd0, data_size}, 32'd0);
      m_buf = 32'd0;
      q_req.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      access(32'h304, 4'b0011, 2'd1, 32'hA5A5_1234, 1, 1, 32'h0F0F_0F0F, 0, 0);

`ifdef DMEM_ALIGN_CHECK_EN
      @(posedge clk); #1;
      mem_en = 1'b1; mem_wen = 4'd0; mem_size = 2'd1; mem_addr = 32'h101;
      @(negedge clk);
      chk("adel_half",  {31'd0, adel_o}, 32'd1);
      chk("ades_half",  {31'd0, ades_o}, 32'd0);
      chk("misal_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1;
      mem_wen = 4'hF; mem_size = 2'd2; mem_addr = 32'h102;
      @(negedge clk);
      chk("ades_word",  {31'd0, ades_o}, 32'd1);
      chk("adel_word",  {31'd0, adel_o}, 32'd0);
      chk("misal_stall2", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1;
      mem_en = 1'b0; mem_wen = 4'd0;
`else
      access(32'h101, 4'b0000, 2'd1, 32'h0, 0, 1, 32'h7777_8888, 0, 0);
`endif

      for (int n = 0; n < 60; n++) begin
         sz = 2'($urandom_range(0, 2));
         a  = $urandom & 32'h0000_FFFF;
         if (sz == 2'd1) a[0] = 1'b0;
         if (sz == 2'd2) a[1:0] = 2'b00;
         if ($urandom_range(0, 1) == 1) begin
            if (sz == 2'd0)      wen = 4'b0001 << a[1:0];
            else if (sz == 2'd1) wen = a[1] ? 4'b1100 : 4'b0011;
            else                 wen = 4'b1111;
         end else wen = 4'b0000;
         ad   = $urandom_range(0, 3);
         dd   = $urandom_range(0, 3);
         fl   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 1 + ad + dd) : 0;
         post = (fl != 0) ? 0 : $urandom_range(0, 3);
         access(a, wen, sz, $urandom, ad, dd, $urandom, fl, post);
      end

      repeat (3) begin @(posedge clk); #1; end
      chk("req_drained", q_req.size(), 32'd0);
      chk("bus_drained", q_bus.size(), 32'd0);
      summary_and_finish();
   end

endmodule

// File: doc/dmem_sram_bridge.md
Name: dmem_sram_bridge

Overview:
- Sequential bridge between the memory-stage byte-lane logic and a SRAM-like data bus with split address/data handshakes.
- Latches each memory-stage access: address, byte strobes, write data and size.
- Issues one bus transaction per access, stalls the pipeline until the data phase completes, and holds read data across external stalls.
- Upstream it consumes the byte-lane select and replicated write data; downstream its read data feeds the load extract/extend logic.

Parameters:
- AW, 32, address width
- DW, 32, data width (strobe width DW/8)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- mem_en  in  1  memory-stage instruction is a load or store
- mem_wen  in  4  byte select from lane logic; nonzero = store
- mem_size  in  2  0=byte, 1=half, 2=word
- mem_addr  in  AW  physical byte address
- mem_wdata  in  DW  lane-replicated store data
- ext_stall  in  1  pipeline frozen by another stage
- flush  in  1  memory-stage instruction killed
- mem_rdata  out  DW  raw load word to extract logic
- stall_o  out  1  memory stage must hold
- adel_o  out  1  load address misaligned (feature only)
- ades_o  out  1  store address misaligned (feature only)
- data_req  out  1  bus request
- data_wr  out  1  1=write
- data_size  out  2  copy of latched size
- data_wstrb  out  4  latched strobes
- data_addr  out  AW  latched address
- data_wdata  out  DW  latched write data
- data_addr_ok  in  1  address phase accepted
- data_data_ok  in  1  data phase complete
- data_rdata  in  DW  bus read data

Behaviour:
- Reset (async, any state) gives: state IDLE; data_req=0; data_wr=0; data_size=0; data_wstrb=0; data_addr=0; data_wdata=0; read buffer=0; discard flag=0. Consequently stall_o=0, mem_rdata=0, adel_o=ades_o=0.
- States: IDLE, ADDR, DATA, DONE. Bus outputs are registered.
- IDLE:
  - Accept when mem_en && !flush.
  - On the accepting edge, latch mem_addr, mem_wen, mem_size and mem_wdata onto the bus outputs.
  - data_wr=|mem_wen; data_req=1 from the next cycle.
  - Next state ADDR.
- ADDR:
  - data_req held 1 and bus fields held stable until data_addr_ok is sampled high.
  - On that edge data_req drops to 0 and the state moves to DATA.
  - Back-to-back requests are never issued.
- DATA, data_data_ok=1:
  - Capture data_rdata into the read buffer.
  - Next state DONE if ext_stall, otherwise IDLE.
- DONE:
  - Buffered data held.
  - Returns to IDLE on the first cycle with !ext_stall.
  - No reissue while the same instruction remains in the stage.
- mem_rdata = data_data_ok in DATA ? data_rdata : read buffer. This gives zero added latency on completion.
- stall_o = (IDLE && mem_en && !flush) || ADDR || (DATA && !data_data_ok). It is 0 in DONE.
- Minimum access is 3 cycles: accept, addr_ok, data_ok. Every addr_ok and data_ok wait cycle adds one.
- Flush in ADDR or DATA:
  - Bus protocol forbids abort, so the transaction runs to data_data_ok.
  - Discard flag set; the read buffer is not updated; the state goes straight to IDLE; the flag clears.
  - stall_o stays 1 until drained.
- Flush in IDLE: no request issued. Flush in DONE: go to IDLE.
- data_data_ok outside DATA and data_addr_ok outside ADDR are ignored.
- mem_wen=0 with mem_en=1 is a load: data_wstrb=0, data_wr=0.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN, when defined:
  - Misaligned condition: (size=1 && addr[0]) or (size=2 && addr[1:0]!=0).
  - In IDLE with mem_en && !flush and a misaligned address, no request is issued and stall_o=0.
  - adel_o (load) or ades_o (store) is asserted combinationally that cycle.
- Macro undefined: adel_o=ades_o=0 constant, and every access is issued as presented.

Decomposition:
- Shared defines header: state encodings (IDLE=0, ADDR=1, DATA=2, DONE=3) and size codes (SZ_B, SZ_H, SZ_W).
- One natural sub-module: addr_align_chk, combinational misalign detector, instantiated only under DMEM_ALIGN_CHECK_EN.

Test Plan:
- Word load, addr 0x100, addr_ok and data_ok 1 cycle later each, rdata 0xDEADBEEF:
  - data_req high exactly 1 cycle; stall_o 1 for 2 cycles; mem_rdata=0xDEADBEEF in the data_ok cycle; data_wr=0.
- Byte store, addr 0x103, wen 4'b1000, wdata 0x5A5A5A5A, addr_ok delayed 3 cycles:
  - data_req, data_addr, data_wstrb and data_wdata stable for 4 cycles; data_wr=1; data_size=0.
- Load completes with ext_stall=1 for 2 further cycles, rdata 0x12345678:
  - State DONE; stall_o=0; mem_rdata holds 0x12345678; no second data_req.
- Flush asserted in DATA with data_ok 2 cycles later, rdata 0xFFFFFFFF:
  - Buffer keeps its old value; stall_o 1 until data_ok; IDLE afterwards.
- rst pulsed high mid-ADDR (asynchronously):
  - data_req falls immediately; all outputs 0; next mem_en issues fresh.
- With DMEM_ALIGN_CHECK_EN, half load at addr 0x101:
  - adel_o=1; stall_o=0; data_req never rises. Word store at 0x102 gives ades_o=1.
